truth_table_engine: RTL
=======================

Name: truth_table_engine

Overview:
Programmable N-input, M-output Boolean function unit. Each output's truth table is loaded serially at run time as either a minterm list (SOP) or a maxterm list (POS). The unit then evaluates single input vectors, or sweeps all 2^N_IN vectors itself to produce a full truth table.
It is the parametrised, run-time-configurable successor to the fixed 3-input, 2-output SOP/POS logic blocks in the lab designs.

Parameters:
N_IN, 3, number of input variables; legal range 2..6; DEPTH = 2^N_IN table entries per output.
N_OUT, 2, number of function outputs; legal range 1..8; SEL_W = max(1, clog2(N_OUT)).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
cfg_start  in  1  IDLE only: begin loading the table for output cfg_sel.
cfg_sel  in  SEL_W  output index being loaded; sampled with cfg_start.
cfg_mode  in  1  sampled with cfg_start; 0 = SOP (bit=1 marks a minterm), 1 = POS (bit=1 marks a maxterm).
cfg_valid  in  1  cfg_bit is valid this cycle.
cfg_bit  in  1  table bit, index order 0..DEPTH-1.
cfg_ready  out  1  high throughout LOAD.
cfg_done  out  1  one-cycle pulse after the last bit is accepted.
sweep_start  in  1  IDLE only: start an automatic sweep of all input vectors.
in_valid  in  1  IDLE only: evaluate in_vec.
in_vec  in  N_IN  input vector; MSB = first variable (x), LSB = last (z).
out_valid  out  1  out_f and out_idx are valid.
out_f  out  N_OUT  function results; bit k = output k.
out_idx  out  N_IN  the input vector that produced out_f.
busy  out  1  high in LOAD or SWEEP.

Behaviour:
- Reset (sync, active-high): state=IDLE; all table bits=0; all modes=0 (SOP). Therefore every function evaluates to 0.
- Reset outputs: cfg_ready=0, cfg_done=0, out_valid=0, out_f=0, out_idx=0, busy=0.
- Reset mid-LOAD or mid-SWEEP aborts the operation. No cfg_done pulse is issued.
- Evaluation: F_k(v) = table_k[v] XOR mode_k. POS semantics: output is 0 at listed maxterms, 1 elsewhere.
- FSM states: IDLE, LOAD, SWEEP.
- IDLE priority per cycle: cfg_start > sweep_start > in_valid. Lower-priority requests in the same cycle are dropped, not queued.
- IDLE, in_valid=1: out_f/out_idx registered, out_valid=1 on the next cycle (latency 1, throughput 1 per cycle).
- IDLE, no in_valid: out_valid=0 on the next cycle. out_f/out_idx hold their last values.
- IDLE->LOAD on cfg_start: latch cfg_sel and cfg_mode; bit counter=0; busy=1 and cfg_ready=1 from the next cycle.
- LOAD: each cycle with cfg_valid=1 writes cfg_bit into table_sel[counter] and increments the counter. Cycles with cfg_valid=0 stall with no timeout.
- LOAD completion: on acceptance of bit DEPTH-1, go to IDLE; cfg_done=1 for exactly the following cycle; the latched mode is committed to mode_sel in the same cycle.
- LOAD other rules: in_valid, sweep_start and cfg_start are ignored; out_valid=0. Other outputs' tables are untouched.
- cfg_sel >= N_OUT: the load runs its full length (cfg_ready, cfg_done behave normally) but writes nothing.
- IDLE->SWEEP on sweep_start: counter=0. Each SWEEP cycle evaluates vector=counter and registers the result with latency 1, giving DEPTH consecutive out_valid pulses with out_idx 0..DEPTH-1.
- SWEEP exit: after vector DEPTH-1 is issued, go to IDLE. The final out_valid appears in the first IDLE cycle; busy falls in that same cycle.
- SWEEP: all requests are ignored.
- Counters are N_IN+1 bits wide internally, so no wrap occurs at DEPTH-1.

Decomposition:
- Package tte_pkg: state enum {IDLE, LOAD, SWEEP}; mode constants MODE_SOP=0, MODE_POS=1; function depth(n)=1<<n.
- Sub-module tt_table_bank: N_OUT x DEPTH bit array plus mode register.
  - Write port: sel, addr, bit, we, mode_we.
  - Combinational read port: vector in, N_OUT results out, with XOR by mode applied.
- The FSM, counters and output registers live in truth_table_engine.

Test Plan:
- Reset then single eval: in_vec=3'b101 -> next cycle out_valid=1, out_f=2'b00, out_idx=5; busy=0.
- Load out0 SOP with bits 1,1,0,0,1,0,0,1 (idx 0..7) -> cfg_ready high for 8 accepted cycles, one cfg_done pulse; eval in_vec=7 -> out_f[0]=1; in_vec=2 -> out_f[0]=0.
- Load out1 POS with bits 0,0,1,1,0,1,1,0 (maxterms 2,3,5,6) -> sweep gives 8 consecutive out_valid, out_idx 0..7, out_f = 11,11,00,00,11,00,00,11.
- Load with cfg_valid toggled every other cycle -> 16 cycles in LOAD, the same table as the contiguous load, exactly one cfg_done.
- Simultaneous cfg_start, sweep_start and in_valid in IDLE -> LOAD entered; no out_valid; no sweep afterwards.
- rst asserted after 4 bits of a load -> next cycle IDLE, cfg_done never pulses; eval of any vector gives out_f=0.

Source files
------------

// File: rtl/tte_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package tte_pkg;

    // Controller states: idle/evaluate, serial table load, full-table sweep.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    // Table polarity: SOP lists minterms (1 = output high), POS lists maxterms (1 = output low).
    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    // Number of truth-table rows for an n-input function.
    function automatic int depth(input int n);
        return 32'sd1 << n;
    endfunction

endpackage

// File: rtl/tt_table_bank.sv
// Storage for N_OUT truth tables of DEPTH bits each, plus one polarity bit per
// table. Writes are synchronous; the read port is purely combinational so the
// engine can register a result one cycle after presenting a vector.
module tt_table_bank
    import tte_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic             wr_bit,
    input  logic             we,
    input  logic             mode_we,
    input  logic             wr_mode,
    input  logic [N_IN-1:0]  rd_vec,
    output logic [N_OUT-1:0] rd_f
);

    localparam int DEPTH = depth(N_IN);

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        logic [DEPTH-1:0] tbl_r;
        logic             mode_r;
        logic             hit_s;

        // A select value outside 0..N_OUT-1 matches no table, so such loads write nothing.
        assign hit_s = (wr_sel == SEL_W'(k));

        // Table bits and polarity for output k; cleared to an all-zero SOP function on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                tbl_r  <= {DEPTH{1'b0}};
                mode_r <= MODE_SOP;
            end else begin
                if (we && hit_s) begin
                    tbl_r[wr_addr] <= wr_bit;
                end
                if (mode_we && hit_s) begin
                    mode_r <= wr_mode;
                end
            end
        end

        // POS inverts the stored bit: listed maxterms read as 0, everything else as 1.
        assign rd_f[k] = tbl_r[rd_vec] ^ mode_r;
    end

endmodule

// File: rtl/truth_table_engine.sv
// Run-time programmable N_IN-input, N_OUT-output Boolean function unit.
// Tables are loaded serially one output at a time; the unit then evaluates
// single vectors (latency 1) or sweeps every input vector on its own.
module truth_table_engine
    import tte_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic             cfg_mode,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic             sweep_start,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_f,
    output logic [N_IN-1:0]  out_idx,
    output logic             busy
);

    localparam int DEPTH = depth(N_IN);
    // One extra bit so the counter never wraps while sitting on the last index.
    localparam int CNT_W = N_IN + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_e             state_r;
    state_e             state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx;
    logic [SEL_W-1:0]   sel_r;
    logic [SEL_W-1:0]   sel_nx;
    logic               mode_lat_r;
    logic               mode_lat_nx;
    logic               tbl_we_s;
    logic               mode_we_s;
    logic               done_nx;
    logic               valid_nx;
    logic [N_IN-1:0]    rd_vec_s;
    logic [N_OUT-1:0]   rd_f_s;

    tt_table_bank #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_sel  (sel_r),
        .wr_addr (cnt_r[N_IN-1:0]),
        .wr_bit  (cfg_bit),
        .we      (tbl_we_s),
        .mode_we (mode_we_s),
        .wr_mode (mode_lat_r),
        .rd_vec  (rd_vec_s),
        .rd_f    (rd_f_s)
    );

    // Read vector: the sweep counter while sweeping, otherwise the external vector.
    always_comb begin
        rd_vec_s = in_vec;
        if (state_r == SWEEP) begin
            rd_vec_s = cnt_r[N_IN-1:0];
        end else begin
            rd_vec_s = in_vec;
        end
    end

    // Next-state logic, table write strobes and next values of the status outputs.
    always_comb begin
        state_nx    = state_r;
        cnt_nx      = cnt_r;
        sel_nx      = sel_r;
        mode_lat_nx = mode_lat_r;
        tbl_we_s    = 1'b0;
        mode_we_s   = 1'b0;
        done_nx     = 1'b0;
        valid_nx    = 1'b0;

        case (state_r)
            IDLE: begin
                // Priority cfg_start > sweep_start > in_valid; losers are dropped.
                if (cfg_start) begin
                    state_nx    = LOAD;
                    cnt_nx      = {CNT_W{1'b0}};
                    sel_nx      = cfg_sel;
                    mode_lat_nx = cfg_mode;
                end else if (sweep_start) begin
                    state_nx = SWEEP;
                    cnt_nx   = {CNT_W{1'b0}};
                end else if (in_valid) begin
                    valid_nx = 1'b1;
                end else begin
                    valid_nx = 1'b0;
                end
            end

            LOAD: begin
                if (cfg_valid) begin
                    tbl_we_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        // Polarity becomes visible together with the final table bit.
                        mode_we_s = 1'b1;
                        done_nx   = 1'b1;
                        state_nx  = IDLE;
                        cnt_nx    = {CNT_W{1'b0}};
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nx = cnt_r;
                end
            end

            SWEEP: begin
                valid_nx = 1'b1;
                if (cnt_r == LAST_IDX) begin
                    state_nx = IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    cnt_nx = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controller state, bit/vector counter and the latched load target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            mode_lat_r <= MODE_SOP;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            sel_r      <= sel_nx;
            mode_lat_r <= mode_lat_nx;
        end
    end

    // Registered outputs; results and their index hold whenever nothing is evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            out_valid <= 1'b0;
            out_f     <= {N_OUT{1'b0}};
            out_idx   <= {N_IN{1'b0}};
            busy      <= 1'b0;
        end else begin
            cfg_ready <= (state_nx == LOAD);
            cfg_done  <= done_nx;
            out_valid <= valid_nx;
            busy      <= (state_nx != IDLE);
            if (valid_nx) begin
                out_f   <= rd_f_s;
                out_idx <= rd_vec_s;
            end else begin
                out_f   <= out_f;
                out_idx <= out_idx;
            end
        end
    end

endmodule
